// File: rtl/pio_pkg.sv
// Shared types and widths for the PIO input shift path.
package pio_pkg;

  localparam int ISR_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH_WAIT = 2'd1,
    PUSH_TRY  = 2'd2
  } state_e;

  // Bit-count fields encode 32 as 0; values past 32 saturate.
  function automatic logic [CNT_W:0] decode_count(input logic [CNT_W-1:0] c);
    logic [CNT_W:0] r;
    if (c == '0) r = 7'd32;
    else if ({1'b0, c} > 7'd32) r = 7'd32;
    else r = {1'b0, c};
    return r;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// STAGES-deep flop chain that brings asynchronous pad inputs into the clock domain.
module pin_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    if (gi == 0) begin : g_first
      assign stage_d = d;
    end else begin : g_next
      assign stage_d = g_stage[gi-1].stage_q;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) stage_q <= '0;
      else        stage_q <= stage_d;
    end
  end

  assign q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/pin_input_shifter.sv
// PIO input shift register with IN/PUSH/autopush handling towards the RX FIFO.
// Optional sticky drop flag: define ISR_OVERFLOW_FLAG_EN.
module pin_input_shifter
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ISR_W-1:0] pins_in,
  input  logic [4:0]       cfg_inBase,
  input  logic             cfg_shiftRight,
  input  logic             cfg_autopush,
  input  logic [CNT_W-1:0] cfg_pushThresh,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             in_ready,
  input  logic             push_valid,
  input  logic             push_block,
  output logic             push_ready,
  output logic [ISR_W-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [CNT_W-1:0] isr_count,
`ifdef ISR_OVERFLOW_FLAG_EN
  output logic             rx_overflow,
  input  logic             overflow_clear,
`endif
  output logic             stall
);

  state_e           state_q, state_d;
  logic [ISR_W-1:0] isr_q, isr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ISR_W-1:0] rx_data_q, rx_data_d;

  logic [ISR_W-1:0]   pins_sync;
  logic [2*ISR_W-1:0] pins_rot;
  logic [CNT_W:0]     n_bits, thresh, cnt_sum;
  logic [CNT_W-1:0]   cnt_new;
  logic [ISR_W-1:0]   in_mask, in_data, isr_new;

  pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(ISR_W)) u_pin_sync (
    .clock (clock),
    .reset (reset),
    .d     (pins_in),
    .q     (pins_sync)
  );

  // Doubling the word turns the window rotate into a plain right shift.
  assign pins_rot = {pins_sync, pins_sync} >> cfg_inBase;
  assign n_bits   = decode_count(in_count);
  assign thresh   = decode_count(cfg_pushThresh);
  assign in_mask  = (n_bits == 7'd32) ? '1 : ((32'h1 << n_bits) - 32'h1);
  assign in_data  = pins_rot[ISR_W-1:0] & in_mask;
  assign cnt_sum  = {1'b0, cnt_q} + n_bits;
  assign cnt_new  = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[CNT_W-1:0];

  always_comb begin
    isr_new = in_data;
    if (n_bits != 7'd32) begin
      if (cfg_shiftRight) isr_new = (isr_q >> n_bits) | (in_data << (7'd32 - n_bits));
      else                isr_new = (isr_q << n_bits) | in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    isr_d      = isr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    in_ready   = 1'b0;
    push_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (push_valid) begin
          push_ready = 1'b1;
          rx_data_d  = isr_q;
          isr_d      = '0;
          cnt_d      = '0;
          state_d    = push_block ? PUSH_WAIT : PUSH_TRY;
        end else if (in_valid) begin
          in_ready = 1'b1;
          if (cfg_autopush && ({1'b0, cnt_new} >= thresh)) begin
            rx_data_d = isr_new;
            isr_d     = '0;
            cnt_d     = '0;
            state_d   = PUSH_WAIT;
          end else begin
            isr_d = isr_new;
            cnt_d = cnt_new;
          end
        end
      end
      PUSH_WAIT: if (rx_ready) state_d = IDLE;
      PUSH_TRY:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      isr_q     <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      isr_q     <= isr_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Decoded from the state register so reset drops rx_valid immediately.
  assign rx_valid  = (state_q == PUSH_WAIT) || (state_q == PUSH_TRY);
  assign rx_data   = rx_data_q;
  assign isr_count = cnt_q;
  assign stall     = (state_q == PUSH_WAIT) || (in_valid && !in_ready) || (push_valid && !push_ready);

`ifdef ISR_OVERFLOW_FLAG_EN
  logic ovf_q;
  logic drop;

  assign drop = (state_q == PUSH_TRY) && !rx_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              ovf_q <= 1'b0;
    else if (drop)           ovf_q <= 1'b1;
    else if (overflow_clear) ovf_q <= 1'b0;
  end

  assign rx_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pin_input_shifter.sv
// Directed bench for pin_input_shifter with an rx_data scoreboard queue.
module tb_pin_input_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pins_in;
  logic [4:0]  cfg_inBase;
  logic        cfg_shiftRight, cfg_autopush;
  logic [5:0]  cfg_pushThresh, in_count;
  logic        in_valid, in_ready, push_valid, push_block, push_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready, stall;
  logic [5:0]  isr_count;
`ifdef ISR_OVERFLOW_FLAG_EN
  logic        rx_overflow, overflow_clear;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  pin_input_shifter #(.SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .pins_in        (pins_in),
    .cfg_inBase     (cfg_inBase),
    .cfg_shiftRight (cfg_shiftRight),
    .cfg_autopush   (cfg_autopush),
    .cfg_pushThresh (cfg_pushThresh),
    .in_valid       (in_valid),
    .in_count       (in_count),
    .in_ready       (in_ready),
    .push_valid     (push_valid),
    .push_block     (push_block),
    .push_ready     (push_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .isr_count      (isr_count),
`ifdef ISR_OVERFLOW_FLAG_EN
    .rx_overflow    (rx_overflow),
    .overflow_clear (overflow_clear),
`endif
    .stall          (stall)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  // Waits (bounded) for rx_valid, then compares rx_data with the queue head.
  task automatic expect_rx(input string tag);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      if (rx_valid) break;
      tick();
    end
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    if (rx_valid && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk({tag, "_data"}, rx_data, w);
    end
  endtask

  task automatic set_pins(input logic [31:0] p);
    pins_in = p;
    repeat (4) tick();
  endtask

  task automatic do_in(input string tag, input logic [5:0] c);
    in_valid = 1'b1;
    in_count = c;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_push(input string tag, input logic blk, input logic [31:0] expw);
    push_valid = 1'b1;
    push_block = blk;
    exp_q.push_back(expw);
    #1;
    chk({tag, "_push_ready"}, {31'd0, push_ready}, 32'd1);
    tick();
    push_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pins_in = '0; cfg_inBase = '0; cfg_shiftRight = 1'b0;
    cfg_autopush = 1'b0; cfg_pushThresh = '0; in_valid = 1'b0; in_count = '0;
    push_valid = 1'b0; push_block = 1'b0; rx_ready = 1'b0;
`ifdef ISR_OVERFLOW_FLAG_EN
    overflow_clear = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_isr_count", {26'd0, isr_count}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    tick();

    // IN 8 bits, base 0, shift left
    set_pins(32'h0000_00A5);
    do_in("in_a5", 6'd8);
    chk("in_a5_count", {26'd0, isr_count}, 32'd8);
    rx_ready = 1'b1;
    do_push("in_a5", 1'b1, 32'h0000_00A5);
    expect_rx("in_a5_rx");
    chk("in_a5_clr", {26'd0, isr_count}, 32'd0);
    tick();
    chk("in_a5_idle", {31'd0, rx_valid}, 32'd0);

    // IN 2 bits, base 31 (window wraps to pin 0), shift right
    set_pins(32'h8000_0001);
    cfg_inBase = 5'd31; cfg_shiftRight = 1'b1;
    do_in("wrap", 6'd2);
    chk("wrap_count", {26'd0, isr_count}, 32'd2);
    do_push("wrap", 1'b1, 32'hC000_0000);
    expect_rx("wrap_rx");
    tick();

    // Autopush at 16 with rx_ready low for 3 cycles
    cfg_inBase = 5'd0; cfg_shiftRight = 1'b0; cfg_autopush = 1'b1;
    cfg_pushThresh = 6'd16; rx_ready = 1'b0;
    set_pins(32'h0000_0012);
    do_in("ap1", 6'd8);
    chk("ap1_count", {26'd0, isr_count}, 32'd8);
    chk("ap1_stall", {31'd0, stall}, 32'd0);
    set_pins(32'h0000_0034);
    exp_q.push_back(32'h0000_1234);
    do_in("ap2", 6'd8);
    expect_rx("ap_rx");
    for (int i = 0; i < 3; i++) begin
      chk("ap_hold_valid", {31'd0, rx_valid}, 32'd1);
      chk("ap_hold_data", rx_data, 32'h0000_1234);
      chk("ap_hold_stall", {31'd0, stall}, 32'd1);
      if (i < 2) tick();
    end
    rx_ready = 1'b1;
    tick();
    chk("ap_done_valid", {31'd0, rx_valid}, 32'd0);
    chk("ap_done_count", {26'd0, isr_count}, 32'd0);
    cfg_autopush = 1'b0;
    do_push("ap_zero", 1'b1, 32'h0);
    expect_rx("ap_zero_rx");
    tick();

    // Non-blocking PUSH of a full word that the FIFO refuses
    set_pins(32'hDEAD_BEEF);
    do_in("full", 6'd0);
    chk("full_count", {26'd0, isr_count}, 32'd32);
    rx_ready = 1'b0;
    do_push("drop", 1'b0, 32'hDEAD_BEEF);
    expect_rx("drop_rx");
    chk("drop_count", {26'd0, isr_count}, 32'd0);
    tick();
    chk("drop_valid_gone", {31'd0, rx_valid}, 32'd0);
`ifdef ISR_OVERFLOW_FLAG_EN
    chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("ovf_clr", {31'd0, rx_overflow}, 32'd0);
`endif

    // PUSH and IN requested together: PUSH wins
    rx_ready = 1'b1;
    in_valid = 1'b1; in_count = 6'd4; push_valid = 1'b1; push_block = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    chk("both_push_ready", {31'd0, push_ready}, 32'd1);
    chk("both_in_ready", {31'd0, in_ready}, 32'd0);
    chk("both_stall", {31'd0, stall}, 32'd1);
    tick();
    in_valid = 1'b0; push_valid = 1'b0;
    expect_rx("both_rx");
    tick();

    // Reset while waiting in PUSH_WAIT
    rx_ready = 1'b0;
    set_pins(32'h0000_005A);
    do_in("rst_in", 6'd8);
    do_push("rst", 1'b1, 32'h0000_005A);
    expect_rx("rst_rx");
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_mid_count", {26'd0, isr_count}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    in_valid = 1'b1; in_count = 6'd1;
    #1;
    chk("rst_mid_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_input_shifter.md
PIN_INPUT_SHIFTER -- requirements
Module: pin_input_shifter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, pin synchronizer depth (legal range 2..3).
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- pins_in  in  32  raw pad input values.
- cfg_inBase  in  5  first pin of the IN window.
- cfg_shiftRight  in  1  1 = shift ISR right, 0 = shift left.
- cfg_autopush  in  1  autopush enable.
- cfg_pushThresh  in  6  autopush threshold; 0 means 32.
- in_valid  in  1  IN request.
- in_count  in  6  bits to shift; 0 means 32.
- in_ready  out  1  IN accepted this cycle.
- push_valid  in  1  PUSH request.
- push_block  in  1  PUSH blocks until delivered.
- push_ready  out  1  PUSH accepted this cycle.
- rx_data  out  32  word to RX FIFO.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  RX FIFO can accept.
- isr_count  out  6  bits currently held (0..32).
- stall  out  1  core must hold the current instruction.

Function
REQ-003 SHALL register pins_in through SYNC_STAGES flops before any use; IN samples only the synchronized value.
REQ-004 SHALL use states IDLE, PUSH_WAIT and PUSH_TRY.
REQ-005 SHALL assert in_ready only when state is IDLE and push_valid is 0.
REQ-006 SHALL assert push_ready only in IDLE; PUSH has priority when push_valid and in_valid are both 1.
REQ-007 SHALL form IN data as the synchronized pins rotated right by cfg_inBase, masked to n = in_count bits; window wrap-around past pin 31 continues at pin 0.
REQ-008 SHALL update the ISR on accepted IN the next edge:
- shift left: (isr << n) | data.
- shift right: (isr >> n) | (data << (32-n)).
- n = 32: the ISR is replaced by data.
REQ-009 SHALL set isr_count to min(isr_count + n, 32) on accepted IN.
REQ-010 SHALL, when cfg_autopush = 1 and the updated count is >= threshold, load rx_data with the updated ISR, clear ISR and count, and enter PUSH_WAIT on the same edge.
REQ-011 SHALL, on an accepted PUSH, load rx_data with the ISR and clear ISR and count; push_block = 1 enters PUSH_WAIT, push_block = 0 enters PUSH_TRY.
REQ-012 SHALL drive rx_valid = 1 in PUSH_WAIT and PUSH_TRY only; latency is one cycle from acceptance to rx_valid.
REQ-013 SHALL leave PUSH_WAIT for IDLE on the edge where rx_ready = 1; otherwise hold rx_data and rx_valid stable.
REQ-014 SHALL leave PUSH_TRY for IDLE after exactly one cycle; the word is dropped if rx_ready = 0 that cycle.
REQ-015 SHALL assert stall = 1 in PUSH_WAIT, and when in_valid or push_valid is 1 but not accepted.

Reset
REQ-016 SHALL, on reset asserted, asynchronously clear ISR, isr_count, rx_data, rx_valid and synchronizer flops, and force the state to IDLE.
REQ-017 SHALL abandon a pending push on reset mid-operation, with rx_valid low in the same cycle.

Configuration
REQ-018 SHALL, with ISR_OVERFLOW_FLAG_EN defined, add ports rx_overflow (out 1) and overflow_clear (in 1); rx_overflow is sticky, set when PUSH_TRY drops a word and cleared by overflow_clear, with set winning on a simultaneous set and clear.
REQ-019 SHALL, without ISR_OVERFLOW_FLAG_EN, have neither port nor flag logic; drops are silent.

Structure
REQ-020 SHALL take the state enum, ISR width (32) and count width (6) from the shared package pio_pkg.
REQ-021 SHALL instantiate sub-module pin_sync (parameterized SYNC_STAGES x 32 flop chain, async active-low reset).

Verification
REQ-022 Bench SHALL cover:
- IN, pins = 0x0000_00A5, base 0, count 8, shift left, ISR 0 -> ISR 0x0000_00A5, isr_count 8.
- IN, pins = 0x8000_0001, base 31, count 2, shift right -> ISR 0xC000_0000 (wrap: bit 0 = pin 31, bit 1 = pin 0).
- Autopush, thresh 16, two IN of 8 bits 0x12 then 0x34, shift left, rx_ready = 0 for 3 cycles -> rx_data 0x0000_1234 held with rx_valid and stall high, then ISR 0 after the handshake.
- Non-blocking PUSH, ISR 0xDEAD_BEEF, rx_ready = 0 -> rx_valid high for 1 cycle, word dropped, isr_count 0, rx_overflow = 1 when the macro is defined.
- push_valid and in_valid asserted together -> push_ready = 1, in_ready = 0, stall = 1.
- Reset asserted mid-PUSH_WAIT -> rx_valid = 0 immediately, state IDLE, isr_count 0.
